// File: rtl/mfcc_pkg.sv
// Shared MFCC chain constants and state types.
// Used by the cepstral frame reader and its bank register file.
package mfcc_pkg;

  localparam int NUM_CEPS   = 12;
  localparam int CEPS_WIDTH = 16;
  localparam int PTR_WIDTH  = $clog2(NUM_CEPS);
  localparam int CNT_WIDTH  = 16;

  localparam logic [PTR_WIDTH-1:0] LAST_PTR =
    PTR_WIDTH'(NUM_CEPS - 1);

  typedef enum logic {
    FREE,
    FULL
  } bank_state_t;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;

endpackage

// File: rtl/ceps_bank_rf.sv
// Two-bank cepstral coefficient register file.
// One write port, one combinational read port.
module ceps_bank_rf
  import mfcc_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [PTR_WIDTH-1:0]  wr_idx,
  input  logic [CEPS_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [PTR_WIDTH-1:0]  rd_idx,
  output logic [CEPS_WIDTH-1:0] rd_data
);

  logic [CEPS_WIDTH-1:0] mem [2][NUM_CEPS];

  always_ff @(posedge clk) begin
    if (we && (wr_idx <= LAST_PTR))
      mem[wr_bank][wr_idx] <= wr_data;
  end

  assign rd_data = (rd_idx <= LAST_PTR) ?
                   mem[rd_bank][rd_idx] : '0;

endmodule

// File: rtl/ceps_frame_reader.sv
// Ping-pong capture of DCT cepstral frames and
// in-order valid/ready streaming to the consumer.
module ceps_frame_reader
  import mfcc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [PTR_WIDTH-1:0]  ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0] ceps_i,
  input  logic                  frame_done_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CEPS_WIDTH-1:0] out_data_o,
  output logic [PTR_WIDTH-1:0]  out_ptr_o,
  output logic                  out_last_o,
  output logic                  overrun_o,
  output logic                  incomplete_o,
  output logic [CNT_WIDTH-1:0]  frame_count_o,
  output logic [CNT_WIDTH-1:0]  drop_count_o
);

  bank_state_t           bank_q [2];
  bank_state_t           bank_d [2];
  rd_state_t             st_q, st_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  discard_q, discard_d;
  logic [NUM_CEPS-1:0]   mask_q, mask_d;
  logic                  valid_d, last_d;
  logic [CEPS_WIDTH-1:0] data_d;
  logic [PTR_WIDTH-1:0]  ptr_d;
  logic                  overrun_d, incomplete_d;
  logic [CNT_WIDTH-1:0]  frame_d, drop_d;
  logic                  drop_inc;

  logic                  wr_en;
  logic [NUM_CEPS-1:0]   wr_bit;
  logic                  xfer;
  logic [PTR_WIDTH-1:0]  rd_idx;
  logic [CEPS_WIDTH-1:0] rd_data;

  assign wr_en  = in_valid_i && !discard_q &&
                  (ceps_ptr_i <= LAST_PTR);
  assign wr_bit = wr_en ?
                  (NUM_CEPS'(1) << ceps_ptr_i) : '0;
  assign xfer   = out_valid_o && out_ready_i;
  assign rd_idx = (st_q == IDLE) ?
                  '0 : out_ptr_o + 1'b1;

  ceps_bank_rf u_rf (
    .clk     (clk),
    .we      (wr_en),
    .wr_bank (wr_bank_q),
    .wr_idx  (ceps_ptr_i),
    .wr_data (ceps_i),
    .rd_bank (rd_bank_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    bank_d       = bank_q;
    st_d         = st_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    discard_d    = discard_q;
    mask_d       = mask_q | wr_bit;
    valid_d      = out_valid_o;
    data_d       = out_data_o;
    ptr_d        = out_ptr_o;
    last_d       = out_last_o;
    overrun_d    = overrun_o;
    incomplete_d = 1'b0;
    frame_d      = frame_count_o;
    drop_d       = drop_count_o;
    drop_inc     = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (bank_q[rd_bank_q] == FULL) begin
          valid_d = 1'b1;
          data_d  = rd_data;
          ptr_d   = '0;
          last_d  = (LAST_PTR == '0);
          st_d    = STREAM;
        end
      end
      STREAM: begin
        if (xfer && out_last_o) begin
          valid_d           = 1'b0;
          last_d            = 1'b0;
          bank_d[rd_bank_q] = FREE;
          rd_bank_d         = ~rd_bank_q;
          frame_d           = frame_count_o + 1'b1;
          st_d              = IDLE;
        end else if (xfer) begin
          data_d = rd_data;
          ptr_d  = rd_idx;
          last_d = (rd_idx == LAST_PTR);
        end
      end
      default: st_d = IDLE;
    endcase

    // bank_d already reflects a bank freed this cycle
    if (frame_done_i) begin
      if (discard_q) begin
        drop_inc  = 1'b1;
        overrun_d = 1'b1;
        if (bank_d[0] == FREE) begin
          discard_d = 1'b0;
          wr_bank_d = 1'b0;
        end else if (bank_d[1] == FREE) begin
          discard_d = 1'b0;
          wr_bank_d = 1'b1;
        end
      end else if (&mask_d) begin
        bank_d[wr_bank_q] = FULL;
        mask_d            = '0;
        if (bank_d[~wr_bank_q] == FREE)
          wr_bank_d = ~wr_bank_q;
        else
          discard_d = 1'b1;
      end else begin
        incomplete_d = 1'b1;
        drop_inc     = 1'b1;
        mask_d       = '0;
      end
    end

    if (drop_inc && (drop_count_o != '1))
      drop_d = drop_count_o + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]     <= FREE;
      bank_q[1]     <= FREE;
      st_q          <= IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      discard_q     <= 1'b0;
      mask_q        <= '0;
      out_valid_o   <= 1'b0;
      out_data_o    <= '0;
      out_ptr_o     <= '0;
      out_last_o    <= 1'b0;
      overrun_o     <= 1'b0;
      incomplete_o  <= 1'b0;
      frame_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      bank_q        <= bank_d;
      st_q          <= st_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      discard_q     <= discard_d;
      mask_q        <= mask_d;
      out_valid_o   <= valid_d;
      out_data_o    <= data_d;
      out_ptr_o     <= ptr_d;
      out_last_o    <= last_d;
      overrun_o     <= overrun_d;
      incomplete_o  <= incomplete_d;
      frame_count_o <= frame_d;
      drop_count_o  <= drop_d;
    end
  end

endmodule

// File: tb/tb_ceps_frame_reader.sv
// Scoreboard bench for ceps_frame_reader.
// Stimulus queues expected words; a negedge monitor checks them.
module tb_ceps_frame_reader;
  import mfcc_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid_i = 1'b0;
  logic [PTR_WIDTH-1:0]  ceps_ptr_i = '0;
  logic [CEPS_WIDTH-1:0] ceps_i = '0;
  logic                  frame_done_i = 1'b0;
  logic                  out_valid_o;
  logic                  out_ready_i = 1'b0;
  logic [CEPS_WIDTH-1:0] out_data_o;
  logic [PTR_WIDTH-1:0]  out_ptr_o;
  logic                  out_last_o;
  logic                  overrun_o;
  logic                  incomplete_o;
  logic [CNT_WIDTH-1:0]  frame_count_o;
  logic [CNT_WIDTH-1:0]  drop_count_o;

  typedef struct {
    logic [CEPS_WIDTH-1:0] d;
    logic [PTR_WIDTH-1:0]  p;
    logic                  l;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;

  logic                  hold = 1'b0;
  logic [CEPS_WIDTH-1:0] hd;
  logic [PTR_WIDTH-1:0]  hp;
  logic                  hl;

  ceps_frame_reader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .ceps_ptr_i    (ceps_ptr_i),
    .ceps_i        (ceps_i),
    .frame_done_i  (frame_done_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_ptr_o     (out_ptr_o),
    .out_last_o    (out_last_o),
    .overrun_o     (overrun_o),
    .incomplete_o  (incomplete_o),
    .frame_count_o (frame_count_o),
    .drop_count_o  (drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid_o, 1);
        chk("hold_data", out_data_o, hd);
        chk("hold_ptr", out_ptr_o, hp);
        chk("hold_last", out_last_o, hl);
      end
      if (out_valid_o && out_ready_i) begin
        exp_t e;
        xfer_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got ptr %0d data %0h, expected none",
                   out_ptr_o, out_data_o);
        end else begin
          e = sb.pop_front();
          chk("word_data", out_data_o, e.d);
          chk("word_ptr", out_ptr_o, e.p);
          chk("word_last", out_last_o, e.l);
        end
      end
      hold = out_valid_o && !out_ready_i;
      hd   = out_data_o;
      hp   = out_ptr_o;
      hl   = out_last_o;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    in_valid_i   = 1'b0;
    frame_done_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wr(input int p, input int v);
    in_valid_i = 1'b1;
    ceps_ptr_i = PTR_WIDTH'(p);
    ceps_i     = CEPS_WIDTH'(v);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic done_pulse;
    frame_done_i = 1'b1;
    tick();
    frame_done_i = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < NUM_CEPS; i++) wr(i, base + i);
    done_pulse();
  endtask

  task automatic expect_frame(input int base);
    exp_t e;
    for (int i = 0; i < NUM_CEPS; i++) begin
      e.d = CEPS_WIDTH'(base + i);
      e.p = PTR_WIDTH'(i);
      e.l = (i == NUM_CEPS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle;
    int c = 0;
    while ((sb.size() != 0 || out_valid_o) && c < 300) begin
      tick();
      c++;
    end
    total++;
    if (c >= 300) begin
      bad++;
      $display("FAIL drain: %0d words left, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_fcnt", frame_count_o, 0);
    chk("rst_dcnt", drop_count_o, 0);

    // single frame, ready high
    out_ready_i = 1'b1;
    expect_frame(100);
    send_frame(100);
    chk("lat_n1", out_valid_o, 0);
    tick();
    chk("lat_n2", out_valid_o, 1);
    wait_idle();
    chk("t1_fcnt", frame_count_o, 1);
    chk("t1_dcnt", drop_count_o, 0);
    chk("t1_ovr", overrun_o, 0);

    // backpressure, ready toggling
    do_reset();
    out_ready_i = 1'b0;
    expect_frame(100);
    send_frame(100);
    begin
      int c = 0;
      int n = 0;
      bit got = 0;
      while (!out_valid_o && c < 10) begin
        tick();
        c++;
      end
      chk("bp_valid", out_valid_o, 1);
      out_ready_i = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
        if (out_valid_o && out_ready_i && out_last_o) begin
          got = 1;
          n = k + 1;
        end
        tick();
        out_ready_i = ~out_ready_i;
      end
      chk("bp_cycles", n, 23);
    end
    out_ready_i = 1'b1;
    wait_idle();
    chk("bp_fcnt", frame_count_o, 1);

    // ping-pong overrun
    do_reset();
    out_ready_i = 1'b0;
    expect_frame(200);
    send_frame(200);
    expect_frame(300);
    send_frame(300);
    chk("ov_before", overrun_o, 0);
    send_frame(400);
    chk("ov_flag", overrun_o, 1);
    chk("ov_drop", drop_count_o, 1);
    out_ready_i = 1'b1;
    wait_idle();
    chk("ov_fcnt", frame_count_o, 2);
    chk("ov_sticky", overrun_o, 1);
    send_frame(500);
    chk("ov_drop2", drop_count_o, 2);
    expect_frame(600);
    send_frame(600);
    wait_idle();
    chk("ov_fcnt2", frame_count_o, 3);

    // incomplete frame
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < NUM_CEPS - 1; i++) wr(i, 16'h0300 + i);
    done_pulse();
    chk("inc_pulse", incomplete_o, 1);
    chk("inc_drop", drop_count_o, 1);
    tick();
    chk("inc_once", incomplete_o, 0);
    tick();
    chk("inc_noout", out_valid_o, 0);
    expect_frame(700);
    send_frame(700);
    wait_idle();
    chk("inc_fcnt", frame_count_o, 1);
    chk("inc_drop2", drop_count_o, 1);

    // descending writes, rewrite and out-of-range index
    do_reset();
    out_ready_i = 1'b1;
    for (int i = NUM_CEPS - 1; i >= 0; i--) begin
      if (i == 5) begin
        wr(5, 16'h000A);
        wr(5, 16'h000B);
      end else begin
        wr(i, 16'h0800 + i);
      end
    end
    wr(13, 16'hDEAD);
    begin
      exp_t e;
      for (int i = 0; i < NUM_CEPS; i++) begin
        e.d = (i == 5) ? 16'h000B : CEPS_WIDTH'(16'h0800 + i);
        e.p = PTR_WIDTH'(i);
        e.l = (i == NUM_CEPS - 1);
        sb.push_back(e);
      end
    end
    done_pulse();
    wait_idle();
    chk("ooo_fcnt", frame_count_o, 1);
    chk("ooo_inc", drop_count_o, 0);

    // reset in the middle of a stream
    do_reset();
    out_ready_i = 1'b1;
    xfer_cnt = 0;
    expect_frame(900);
    send_frame(900);
    begin
      int c = 0;
      while (xfer_cnt < 4 && c < 50) begin
        tick();
        c++;
      end
      chk("mid_reach4", (xfer_cnt >= 4), 1);
    end
    rst = 1'b1;
    tick();
    chk("mid_valid", out_valid_o, 0);
    chk("mid_data", out_data_o, 0);
    chk("mid_ptr", out_ptr_o, 0);
    chk("mid_last", out_last_o, 0);
    chk("mid_ovr", overrun_o, 0);
    chk("mid_inc", incomplete_o, 0);
    chk("mid_fcnt", frame_count_o, 0);
    chk("mid_dcnt", drop_count_o, 0);
    rst = 1'b0;
    sb.delete();
    tick();
    chk("mid_quiet", out_valid_o, 0);
    expect_frame(1000);
    send_frame(1000);
    wait_idle();
    chk("mid_fcnt2", frame_count_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ceps_frame_reader.md
# ceps_frame_reader

Consumer end of the DCT output interface in the MFCC chain. It captures the per-coefficient writes (valid, index, value) plus the end-of-frame pulse from `dct` into a ping-pong pair of frame banks. It then streams each complete cepstral frame, in index order, over a valid/ready interface to the downstream consumer (SPI/UART packer or classifier). It decouples DCT timing from a backpressuring reader and reports lost and malformed frames.

## Interface
- `NUM_CEPS`, 12, coefficients per frame.
- `CEPS_WIDTH`, 16, coefficient width, two's complement.
- `PTR_WIDTH`, `$clog2(NUM_CEPS)`, index width.
- `CNT_WIDTH`, 16, width of frame/drop counters.

Ports:
- `clk`  in  1  clock; everything on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  coefficient write strobe (from `dct_valid_o`).
- `ceps_ptr_i`  in  PTR_WIDTH  coefficient index (from `ceps_ptr_o`).
- `ceps_i`  in  CEPS_WIDTH  coefficient value (from `ceps_out`).
- `frame_done_i`  in  1  end-of-frame pulse (from `dct_done_o`).
- `out_valid_o`  out  1  output word valid.
- `out_ready_i`  in  1  consumer accepts word.
- `out_data_o`  out  CEPS_WIDTH  coefficient value.
- `out_ptr_o`  out  PTR_WIDTH  coefficient index of `out_data_o`.
- `out_last_o`  out  1  high with index NUM_CEPS-1.
- `overrun_o`  out  1  sticky; a frame was dropped for lack of a free bank.
- `incomplete_o`  out  1  one-cycle pulse; a frame ended with missing indices.
- `frame_count_o`  out  CNT_WIDTH  frames fully streamed out, wraps.
- `drop_count_o`  out  CNT_WIDTH  frames dropped (overrun or incomplete), saturates.

## Operation
- Two banks, each `NUM_CEPS` x `CEPS_WIDTH`, with state FREE or FULL. `wr_bank` selects the capture target. `rd_bank` selects the next bank to stream. Both reset to 0.
- Capture:
  - On `in_valid_i` with `ceps_ptr_i < NUM_CEPS` and not discarding, write `bank[wr_bank][ptr]` and set bit `ptr` of `wr_mask`.
  - Indices ≥ NUM_CEPS are ignored.
  - Rewriting an index overwrites the value; the last write wins.
- On `frame_done_i`:
  - `wr_mask` all ones and not discarding: mark `wr_bank` FULL and clear `wr_mask`.
    - Other bank FREE: toggle `wr_bank`.
    - Other bank FULL: enter discard mode.
  - `wr_mask` incomplete: pulse `incomplete_o`, increment `drop_count_o`, clear `wr_mask`, bank stays FREE.
  - In discard mode: increment `drop_count_o` and set `overrun_o`.
    - If a bank is now FREE, leave discard mode and point `wr_bank` at it.
    - Otherwise stay in discard mode.
- Discard mode: all `in_valid_i` writes are ignored.
- Read FSM, IDLE → STREAM:
  - IDLE: if `bank[rd_bank]` is FULL, load index 0 into the output registers, assert `out_valid_o`, go to STREAM.
  - STREAM: on `out_valid_o && out_ready_i`, advance the index and reload the output registers.
  - On the transfer with `out_last_o`: mark `rd_bank` FREE, toggle `rd_bank`, increment `frame_count_o`, go to IDLE.
- Same-cycle events:
  - A write coinciding with `frame_done_i` is included before the completeness check.
  - A bank freed by a last transfer in the same cycle as `frame_done_i` counts as FREE for the swap decision.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_data_o`=0, `out_ptr_o`=0, `out_last_o`=0.
  - `overrun_o`=0, `incomplete_o`=0, both counters 0.
  - Both banks FREE, `wr_mask`=0, discard mode off, FSM IDLE.
- Latency: `frame_done_i` at cycle N → bank FULL at N+1 → `out_valid_o` with index 0 at N+2.
- With `out_ready_i` held high, one word per cycle: NUM_CEPS consecutive cycles per frame, then one IDLE cycle before the next FULL bank starts.
- While `out_valid_o && !out_ready_i`, `out_data_o`, `out_ptr_o` and `out_last_o` hold stable.
- `out_valid_o` never drops without a transfer.
- All outputs are registered; there is no combinational path from `out_ready_i` to `out_valid_o`.
- Reset mid-frame or mid-stream discards all stored data and returns to reset values the next cycle.

## Structure
- Shared package `mfcc_pkg`:
  - constants `NUM_CEPS`, `CEPS_WIDTH`;
  - `bank_state_t` {FREE, FULL};
  - `rd_state_t` {IDLE, STREAM}.
- One sub-module, `ceps_bank_rf`: 2×NUM_CEPS register file with one write port (bank, index, data) and one combinational read port (bank, index).
- Capture logic, bank bookkeeping and the read FSM stay in the top module.

## Test plan
- Single frame: write indices 0..11 with values 100+i, pulse `frame_done_i`, `out_ready_i`=1 → words 100..111 with ptr 0..11. `out_last_o` only on ptr 11, `frame_count_o`=1, first valid 2 cycles after done.
- Backpressure: same frame with `out_ready_i` toggling 1/0 each cycle → 12 words in order, each held stable while ready=0, 23 cycles from first valid to last transfer.
- Ping-pong overrun: `out_ready_i`=0, deliver 3 complete frames → frames 1–2 FULL, frame 3 dropped, `overrun_o`=1, `drop_count_o`=1. After release, output is frame 1 then frame 2.
- Incomplete frame: write indices 0..10 only, pulse done → `incomplete_o` pulses once, `drop_count_o`=1, no output. A following full frame streams normally from the same bank.
- Out-of-order writes: indices written in descending order with index 5 written twice (values 0x0A then 0x0B) → output in ascending order with word 5 = 0x0B. A write with ptr=13 is ignored.
- Reset mid-stream: assert `rst` after 4 words transferred → next cycle all outputs at reset values; a fresh frame then streams from index 0 with `frame_count_o`=1.
